// File: rtl/encrypt_top.sv
// Hardwired message-encryption engine: reads a padded message and three control
// bytes from its data memory and writes back a 64-byte LFSR-scrambled, parity-tagged copy.

module encrypt_dm (
   input  logic       clk,
   input  logic       we,
   input  logic [7:0] waddr,
   input  logic [7:0] wdata,
   input  logic [7:0] raddr,
   output logic [7:0] rdata
);
   logic [7:0] Core [0:255];

   // No reset on the array: contents survive Reset so they can be preloaded.
   always_ff @(posedge clk) begin
      if (we) Core[waddr] <= wdata;
   end

   assign rdata = Core[raddr];
endmodule

module encrypt_top #(
   parameter ROM_FILE = "machine_code_1.txt"
) (
   input  logic Clk,
   input  logic Reset,
   input  logic Start,
   output logic Ack
);
   // The program image name only keeps the slot-compatible interface; nothing is fetched.
   if ($bits(ROM_FILE) == 0) begin : g_rom_unused
   end

   typedef enum logic [2:0] {IDLE, LD_PRE, LD_TAP, LD_SEED, ENC, DONE} state_t;

   state_t     state, state_next;
   logic [5:0] idx;
   logic [7:0] pre_len;
   logic [6:0] taps;
   logic [6:0] lfsr;
   logic [6:0] lfsr_next;
   logic [7:0] src_off;
   logic [7:0] pad_byte;
   logic [7:0] enc_byte;
   logic [7:0] raddr;
   logic [7:0] rdata;
   logic [7:0] waddr;
   logic [7:0] wdata;
   logic       we;

   function automatic logic [6:0] tap_lookup(input logic [7:0] pt_no);
      case (pt_no)
         8'd1:    tap_lookup = 7'h48;
         8'd2:    tap_lookup = 7'h78;
         8'd3:    tap_lookup = 7'h72;
         8'd4:    tap_lookup = 7'h6A;
         8'd5:    tap_lookup = 7'h69;
         8'd6:    tap_lookup = 7'h5C;
         8'd7:    tap_lookup = 7'h7E;
         8'd8:    tap_lookup = 7'h7B;
         default: tap_lookup = 7'h60;
      endcase
   endfunction

   encrypt_dm DM (
      .clk   (Clk),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .raddr (raddr),
      .rdata (rdata)
   );

   // Message offset for output byte idx; only meaningful once idx >= pre_len.
   assign src_off   = {2'b00, idx} - pre_len;
   assign pad_byte  = (({2'b00, idx} < pre_len) || (src_off > 8'd60)) ? 8'h20 : rdata;
   assign enc_byte  = pad_byte ^ {1'b0, lfsr};
   assign wdata     = {^enc_byte[6:0], enc_byte[6:0]};
   assign waddr     = {2'b01, idx};
   assign lfsr_next = {lfsr[5:0], ^(lfsr & taps)};

   always_ff @(posedge Clk) begin
      if (Reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      raddr      = 8'd0;
      we         = 1'b0;
      case (state)
         LD_PRE:  raddr = 8'd61;
         LD_TAP:  raddr = 8'd62;
         LD_SEED: raddr = 8'd63;
         ENC:     raddr = src_off;
         default: raddr = 8'd0;
      endcase
      if (Reset || Start) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:    state_next = LD_PRE;
            LD_PRE:  state_next = LD_TAP;
            LD_TAP:  state_next = LD_SEED;
            LD_SEED: state_next = ENC;
            ENC: begin
               we = 1'b1;
               if (idx == 6'd63) state_next = DONE;
            end
            DONE:    state_next = DONE;
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         idx     <= 6'd0;
         pre_len <= 8'd0;
         taps    <= 7'd0;
         lfsr    <= 7'd0;
         Ack     <= 1'b0;
      end else begin
         Ack <= (state_next == DONE);
         case (state)
            LD_PRE:  pre_len <= rdata;
            LD_TAP:  taps    <= tap_lookup(rdata);
            LD_SEED: lfsr    <= (rdata[6:0] == 7'd0) ? 7'd1 : rdata[6:0];
            ENC: begin
               idx  <= idx + 6'd1;
               lfsr <= lfsr_next;
            end
            default: ;
         endcase
         if (state_next == IDLE) idx <= 6'd0;
      end
   end
endmodule

// File: tb/tb_encrypt_top.sv
// Bench for encrypt_top: a timeline model of Ack plus a byte-level model of the
// encrypted output, compared every cycle, with a few hand-computed anchors.

module tb_encrypt_top;
  logic Clk = 1'b0;
  logic Reset;
  logic Start;
  logic Ack;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] shadow [0:255];
  logic [7:0] exp_q[$];
  logic [7:0] nom_out [0:63];
  logic [7:0] ref_out [0:63];
  logic [6:0] tap_tab [0:8] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B};

  int   m_edge = 0;
  logic m_ack  = 1'b0;
  logic chk_en = 1'b0;

  encrypt_top dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Start (Start),
    .Ack   (Ack)
  );

  // ---------------- clock ----------------
  always #5 Clk = ~Clk;

  // ---------------- scoreboard helpers ----------------
  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Expected 64 output bytes from the preloaded memory image.
  task automatic build_expected();
    int pre, pt, l, t, p, e, par, src;
    pre = shadow[61];
    pt  = shadow[62];
    t   = (pt > 8) ? tap_tab[0] : tap_tab[pt];
    l   = shadow[63] % 128;
    if (l == 0) l = 1;
    exp_q.delete();
    for (int i = 0; i < 64; i++) begin
      src = i - pre;
      if (i < pre || src > 60) p = 32;
      else                     p = shadow[src];
      e   = (p ^ l) % 128;
      par = $countones(e) % 2;
      exp_q.push_back(8'(par * 128 + e));
      l = ((l * 2) % 128) + ($countones(l & t) % 2);
    end
  endtask

  // Timeline model: counts edges since the engine left idle.
  always @(posedge Clk) begin
    if (Reset || Start) begin
      m_edge = 0;
      m_ack  = 1'b0;
    end else if (m_edge < 68) begin
      m_edge++;
      if (m_edge == 1) build_expected();
      if (m_edge == 68) m_ack = 1'b1;
    end
  end

  // Per-cycle compare.
  always @(negedge Clk) begin
    if (chk_en) begin
      check8("ack", {7'd0, Ack}, {7'd0, m_ack});
      if (m_edge >= 5 && m_edge <= 68)
        check8("out_byte", dut.DM.Core[64 + m_edge - 5], exp_q[m_edge - 5]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic set_core(input int a, input logic [7:0] v);
    dut.DM.Core[a] = v;
    shadow[a]      = v;
  endtask

  task automatic load_msg(input string s, input int pre, input int pt, input int seed);
    for (int i = 0; i < 61; i++) set_core(i, (i < s.len()) ? s[i] : 8'h20);
    set_core(61, 8'(pre));
    set_core(62, 8'(pt));
    set_core(63, 8'(seed));
  endtask

  task automatic load_random_msg();
    for (int i = 0; i < 61; i++) set_core(i, 8'($urandom_range(32, 126)));
    set_core(61, 8'($urandom_range(0, 80)));
    set_core(62, 8'($urandom_range(0, 15)));
    set_core(63, 8'($urandom_range(0, 255)));
  endtask

  // Release the engine and measure edges until Ack (bounded).
  task automatic run_once(input string name);
    int n;
    Reset = 1'b0;
    Start = 1'b0;
    n = 0;
    while (Ack !== 1'b1 && n < 200) begin
      @(negedge Clk);
      n++;
    end
    check8({name, "_latency"}, 8'(n), 8'd68);
  endtask

  task automatic hold_start();
    Start = 1'b1;
    cycles(1);
  endtask

  task automatic check_regions(input string name);
    int bad_lo, bad_hi;
    bad_lo = 0;
    bad_hi = 0;
    for (int i = 0; i < 64; i++)    if (dut.DM.Core[i] !== shadow[i]) bad_lo++;
    for (int i = 128; i < 256; i++) if (dut.DM.Core[i] !== shadow[i]) bad_hi++;
    check8({name, "_input_intact"}, 8'(bad_lo), 8'd0);
    check8({name, "_upper_intact"}, 8'(bad_hi), 8'd0);
  endtask

  task automatic save_out(input bit to_nom);
    for (int i = 0; i < 64; i++) begin
      if (to_nom) nom_out[i] = dut.DM.Core[64 + i];
      else        ref_out[i] = dut.DM.Core[64 + i];
    end
  endtask

  task automatic compare_out(input string name, input bit vs_nom);
    int bad;
    bad = 0;
    for (int i = 0; i < 64; i++)
      if (dut.DM.Core[64 + i] !== (vs_nom ? nom_out[i] : ref_out[i])) bad++;
    check8(name, 8'(bad), 8'd0);
  endtask

  // ---------------- main sequence ----------------
  string nominal = " Knowledge comes, but wisdom lingers.    ";

  initial begin
    int n;
    Reset = 1'b1;
    Start = 1'b1;
    for (int i = 0; i < 256; i++) shadow[i] = 8'h00;
    for (int i = 64; i < 128; i++) set_core(i, 8'h00);
    for (int i = 128; i < 256; i++) set_core(i, 8'($urandom_range(0, 255)));
    load_msg(nominal, 12, 0, 23);
    cycles(2);
    chk_en = 1'b1;
    check8("reset_ack", {7'd0, Ack}, 8'd0);
    Reset = 1'b0;
    cycles(1);

    // Nominal run with hand-computed anchors.
    run_once("nominal");
    check8("nom_core64", dut.DM.Core[64], 8'hB7);
    check8("nom_core65", dut.DM.Core[65], 8'h8E);
    check8("nom_core66", dut.DM.Core[66], 8'h7D);
    check8("model_pin0", exp_q[0], 8'hB7);
    check8("model_pin2", exp_q[2], 8'h7D);
    check_regions("nominal");
    save_out(1'b1);

    // Start after DONE drops Ack at the next edge.
    Start = 1'b1;
    cycles(1);
    check8("ack_drop", {7'd0, Ack}, 8'd0);

    // pt_no 1, seed 1, then seed 0 must match.
    load_msg(nominal, 12, 1, 1);
    cycles(1);
    run_once("pt1_seed1");
    check8("pt1_core64", dut.DM.Core[64], 8'h21);
    save_out(1'b0);
    hold_start();
    set_core(63, 8'h00);
    cycles(1);
    run_once("seed0");
    compare_out("seed0_same_as_seed1", 1'b0);

    // pt_no above 8 uses entry 0.
    hold_start();
    load_msg(nominal, 12, 12, 23);
    cycles(1);
    run_once("pt12");
    compare_out("pt12_same_as_pt0", 1'b1);

    // Padding boundaries.
    hold_start();
    load_msg(nominal, 15, 3, 77);
    cycles(1);
    run_once("pre15");
    hold_start();
    load_msg(nominal, 70, 5, 99);
    cycles(1);
    run_once("pre70");
    save_out(1'b0);
    hold_start();
    load_msg("", 0, 5, 99);
    cycles(1);
    run_once("all_spaces");
    compare_out("pre70_is_all_spaces", 1'b0);

    // Reset in the middle of encryption, then a clean rerun.
    hold_start();
    load_msg(nominal, 12, 0, 23);
    cycles(1);
    Start = 1'b0;
    n = 0;
    while (m_edge < 25 && n < 100) begin
      @(negedge Clk);
      n++;
    end
    check8("midrun_reached", 8'(m_edge), 8'd25);
    Reset = 1'b1;
    cycles(2);
    check8("midrun_ack_low", {7'd0, Ack}, 8'd0);
    run_once("after_reset");
    compare_out("after_reset_same_as_nominal", 1'b1);

    // Randomized runs.
    for (int r = 0; r < 6; r++) begin
      hold_start();
      load_random_msg();
      cycles(1);
      run_once("random");
      check_regions("random");
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/encrypt_top.md
Name: encrypt_top

Overview:
- Top-level message-encryption engine for Program 1.
- Owns a 256-byte data memory and reads a padded ASCII message plus three control bytes from it.
- Writes a 64-byte LFSR-encrypted, parity-tagged message back into the same memory, then raises Ack.
- The sequencer is hardwired; no instruction fetch takes place.

Parameters:
- ROM_FILE, "machine_code_1.txt", program-image filename. Kept so the block fits the program-ROM slot. Never read; the behaviour is fixed.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  high holds the engine idle; low lets it run.
- Ack  output  1  high when the output message is complete.

Behaviour:
- Memory:
  - Internal instance named DM, holding array Core[0:255] of 8-bit words.
  - Combinational read, synchronous write.
  - Reset never clears Core, so the bench can preload it while Reset is high.
- Input map:
  - Core[0..60]: message bytes, space-padded.
  - Core[61]: pre_length.
  - Core[62]: pt_no.
  - Core[63]: seed.
- Output map: Core[64..127].
- The engine never writes Core[0..63] or Core[128..255].
- Tap table, indexed by pt_no 0..8: 60,48,78,72,6A,69,5C,7E,7B (hex). A pt_no above 8 selects entry 0.
- Seed: uses seed[6:0]. A seed of 0 is replaced by 7'h01.
- LFSR sequence:
  - L0 = seed.
  - L(k+1) = {Lk[5:0], ^(Lk & taps)}.
  - 7 bits wide; wraps naturally with period 127.
- Padded byte P(i), for i = 0..63:
  - 0x20 if i < pre_length.
  - Otherwise, with s = i − pre_length: Core[s] if s ≤ 60, else 0x20.
  - pre_length is treated as unsigned 8-bit; values of 64 or more give all spaces.
- Output byte:
  - E = P(i) XOR {1'b0, L(i)}.
  - Then E[7] is replaced by ^E[6:0] (even parity over the low 7 bits).
  - The written byte is Core[64+i] = E.
- FSM: IDLE → LD_PRE → LD_TAP → LD_SEED → ENC → DONE.
  - IDLE: Ack=0, counter i=0. Leaves IDLE on a rising edge where Reset=0 and Start=0.
  - LD_PRE, LD_TAP, LD_SEED: one cycle each; capture Core[61], the tap table entry for Core[62], and Core[63] into registers.
  - ENC: one output byte written per cycle (i = 0..63), and the LFSR is advanced each cycle. Exits after i = 63 is written.
  - DONE: Ack=1, held until Reset or Start is asserted.
- Latency: Ack is high after the 68th rising edge, counting the edge that leaves IDLE as edge 1.
- Reset (any state): next state IDLE, Ack=0, internal registers cleared. Output bytes already written stay in memory.
- Start high in any non-IDLE state: next state IDLE, Ack=0. The run aborts.
- Start falling again after DONE or an abort starts a full rerun with fresh reads of Core[61..63].
- Reset and Start both high: reset behaviour applies.
- Ack is a registered output; it reads 0 during and immediately after reset.

Test Plan:
- Nominal run:
  - Setup: Core[0..40] = " Knowledge comes, but wisdom lingers.    "; Core[41..60] = 0x20; pre_length = 12; pt_no = 0; seed = 23. Hold Reset 2 cycles, then Start 1 more cycle, then release.
  - Expected: Core[64] = B7, Core[65] = 8E, Core[66] = 7D, with all 64 bytes matching the formula. Ack rises at edge 68. Core[0..63] unchanged.
- Pattern and seed edge cases:
  - pt_no = 1, seed = 1 → Core[64] = 21.
  - Repeat with seed = 0 → identical output (seed treated as 01).
  - pt_no = 12 → output identical to pt_no = 0.
- Padding boundaries:
  - pre_length = 15 → Core[64..78] are spaces XOR LFSR, and Core[79] uses Core[0].
  - pre_length = 70 → all 64 bytes derive from 0x20.
- Reset mid-run:
  - Assert Reset at ENC byte 20 → Ack stays 0, FSM returns to IDLE.
  - Release Reset with Start low → full rerun, correct result, Ack at edge 68.
- Restart and isolation:
  - After DONE, raise Start → Ack drops next edge.
  - Change seed, drop Start → new output and Ack again.
  - Preloaded Core[128..255] pattern is untouched throughout.
